// File: rtl/ssp_pkg.sv
// Shared SSP package: FIFO width/depth defaults and the pointer and level
// widths derived from them. Used by both the TX and RX FIFOs.
package ssp_pkg;

  localparam int unsigned SspFifoWidth = 8;
  localparam int unsigned SspFifoDepth = 4;

  // Pointer wraps naturally at depth; level needs one extra bit to hold depth.
  localparam int unsigned SspPtrW = $clog2(SspFifoDepth);
  localparam int unsigned SspLvlW = SspPtrW + 1;

endpackage

// File: rtl/ssp_tx_fifo_if.sv
// SSP TX FIFO bus interface.
//   APB side  : PSEL, PWRITE, PWDATA (push requests), SSPTXINTR, overrun
//   TX side   : TxData, tx_valid, tx_ready (valid/ready drain)
//   Status    : fifo_empty, tx_level
// Modport master drives requests and ready; modport slave is the FIFO itself.
interface ssp_tx_fifo_if
  import ssp_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = SspFifoWidth,
  parameter int unsigned FIFO_DEPTH = SspFifoDepth
);

  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

  logic                  PSEL;
  logic                  PWRITE;
  logic [FIFO_WIDTH-1:0] PWDATA;
  logic [FIFO_WIDTH-1:0] TxData;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  SSPTXINTR;
  logic                  fifo_empty;
  logic [LvlW-1:0]       tx_level;
  logic                  overrun;

  modport master (
    output PSEL, PWRITE, PWDATA, tx_ready,
    input  TxData, tx_valid, SSPTXINTR, fifo_empty, tx_level, overrun
  );

  modport slave (
    input  PSEL, PWRITE, PWDATA, tx_ready,
    output TxData, tx_valid, SSPTXINTR, fifo_empty, tx_level, overrun
  );

endinterface

// File: rtl/ssp_tx_fifo.sv
// SSP transmit FIFO. CPU pushes words over APB, transmit logic drains them
// via valid/ready. Reports full (SSPTXINTR), empty, fill level and a sticky
// overrun flag for writes attempted while full.
// Ports:
//   PCLK  - clock, all state changes on rising edge
//   CLEAR - synchronous active-high reset; clears pointers, level, overrun, storage
//   bus   - ssp_tx_fifo_if slave modport (APB push, TX drain, status)
module ssp_tx_fifo
  import ssp_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = SspFifoWidth,
  parameter int unsigned FIFO_DEPTH = SspFifoDepth
) (
  input logic           PCLK,
  input logic           CLEAR,
  ssp_tx_fifo_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]       count_q, count_d;
  logic                  overrun_q, overrun_d;

  logic full, empty, wr_req, push, pop;

  // Full/empty come from the registered count only, so a write while full is
  // dropped even when a pop happens in the same cycle.
  always_comb begin
    full   = (count_q == LvlW'(FIFO_DEPTH));
    empty  = (count_q == '0);
    wr_req = bus.PSEL && bus.PWRITE;
    push   = wr_req && !full;
    pop    = !empty && bus.tx_ready;
  end

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q | (wr_req && full);

    if (push) begin
      mem_d[wr_ptr_q] = bus.PWDATA;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + LvlW'(1);
      2'b01:   count_d = count_q - LvlW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Head word is forced to zero when empty so stale storage never leaks out.
  always_comb begin
    bus.TxData     = empty ? '0 : mem_q[rd_ptr_q];
    bus.tx_valid   = !empty;
    bus.SSPTXINTR  = full;
    bus.fifo_empty = empty;
    bus.tx_level   = count_q;
    bus.overrun    = overrun_q;
  end

endmodule
